wb_stream_bridge: RTL

//  Wishbone B4 pipelined slave that couples the bus to two 32-bit valid/ready streams.
//  Bus writes to TXDATA push into a TX FIFO that drains on the TX stream port.
//  RX stream beats fill an RX FIFO that the bus pops by reading RXDATA.

---
 rtl/wb_stream_bridge_if.sv | 46 ++++
 rtl/wb_stream_bridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_stream_bridge_if.sv
// Bundle of the Wishbone B4 pipelined slave bus and the two 32-bit stream ports
// served by wb_stream_bridge.
//   slave  modport: the bridge (bus slave, TX stream source, RX stream sink)
//   master modport: whatever drives the bus and the stream partners
// Signals:
//   WB_ADR_I/DAT_I/WE_I/STB_I/CYC_I/CTI_I  bus request
//   WB_DAT_O/ACK_O/ERR_O/RTY_O/STALL_O     bus response
//   TX_VALID_O/TX_DATA_O/TX_READY_I        outbound stream (bridge -> sink)
//   RX_VALID_I/RX_DATA_I/RX_READY_O        inbound stream (source -> bridge)
interface wb_stream_bridge_if;
  logic [31:0] WB_ADR_I;
  logic [31:0] WB_DAT_I;
  logic [31:0] WB_DAT_O;
  logic        WB_WE_I;
  logic        WB_STB_I;
  logic        WB_CYC_I;
  logic [2:0]  WB_CTI_I;
  logic        WB_ACK_O;
  logic        WB_ERR_O;
  logic        WB_RTY_O;
  logic        WB_STALL_O;
  logic        TX_VALID_O;
  logic [31:0] TX_DATA_O;
  logic        TX_READY_I;
  logic        RX_VALID_I;
  logic [31:0] RX_DATA_I;
  logic        RX_READY_O;

  modport slave (
    input  WB_ADR_I, WB_DAT_I, WB_WE_I, WB_STB_I, WB_CYC_I, WB_CTI_I,
    output WB_DAT_O, WB_ACK_O, WB_ERR_O, WB_RTY_O, WB_STALL_O,
    output TX_VALID_O, TX_DATA_O,
    input  TX_READY_I,
    input  RX_VALID_I, RX_DATA_I,
    output RX_READY_O
  );

  modport master (
    output WB_ADR_I, WB_DAT_I, WB_WE_I, WB_STB_I, WB_CYC_I, WB_CTI_I,
    input  WB_DAT_O, WB_ACK_O, WB_ERR_O, WB_RTY_O, WB_STALL_O,
    input  TX_VALID_O, TX_DATA_O,
    output TX_READY_I,
    output RX_VALID_I, RX_DATA_I,
    input  RX_READY_O
  );
endinterface

// File: rtl/wb_stream_bridge.sv
// Wishbone B4 pipelined slave bridging the bus to two 32-bit valid/ready streams.
// Bus writes to TXDATA fill a TX FIFO drained by the TX stream; RX stream beats
// fill an RX FIFO popped by bus reads of RXDATA. Every accepted request gets
// exactly one ACK or ERR on the following cycle; the bus never stalls.
// Ports:
//   WB_CLK_I  bus clock, all logic on posedge
//   WB_RST_I  asynchronous active-high reset
//   bus       wb_stream_bridge_if.slave (Wishbone request/response + both streams)
//   IRQ_O     registered irq_en & RX FIFO non-empty
// Register map (ADR[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
module wb_stream_bridge #(
  parameter int DEPTH = 16
) (
  input  logic                  WB_CLK_I,
  input  logic                  WB_RST_I,
  wb_stream_bridge_if.slave     bus,
  output logic                  IRQ_O
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;
  logic [CW-1:0] tx_count_nxt, rx_count_nxt;
  logic          tx_ovf, rx_unf, irq_en, irq_en_nxt;
  logic          ack_p1, err_p1, irq_p1;
  logic [31:0]   dat_p1;

  logic          accept, wr, rd;
  logic [1:0]    sel;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push_req, tx_push, tx_reject, tx_pop;
  logic          rx_pop_req, rx_pop, rx_reject, rx_push, rx_push_eff;
  logic          ctrl_wr, status_wr, tx_flush, rx_flush;
  logic [31:0]   rd_data;

  // Only ADR[3:2] is decoded; CTI is ignored (every beat is a single transfer).
  logic unused_bits;
  assign unused_bits = ^{bus.WB_CTI_I, bus.WB_ADR_I[31:4], bus.WB_ADR_I[1:0]};

  assign accept = bus.WB_CYC_I & bus.WB_STB_I;
  assign sel    = bus.WB_ADR_I[3:2];
  assign wr     = accept & bus.WB_WE_I;
  assign rd     = accept & ~bus.WB_WE_I;

  // Full/empty come from the counts registered before this edge, so a same-cycle
  // stream pop/push never rescues a rejected bus push/pop.
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign tx_push_req = wr & (sel == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_reject   = tx_push_req & tx_full;
  assign tx_pop      = ~tx_empty & bus.TX_READY_I;

  assign rx_pop_req  = rd & (sel == 2'd1);
  assign rx_pop      = rx_pop_req & ~rx_empty;
  assign rx_reject   = rx_pop_req & rx_empty;
  assign rx_push     = bus.RX_VALID_I & ~rx_full;

  assign ctrl_wr     = wr & (sel == 2'd3);
  assign status_wr   = wr & (sel == 2'd2);
  assign tx_flush    = ctrl_wr & bus.WB_DAT_I[0];
  assign rx_flush    = ctrl_wr & bus.WB_DAT_I[1];
  // An RX beat landing in the flush cycle is handshaken but discarded.
  assign rx_push_eff = rx_push & ~rx_flush;

  assign irq_en_nxt  = ctrl_wr ? bus.WB_DAT_I[2] : irq_en;

  always_comb begin
    tx_count_nxt = tx_count;
    if (tx_push & ~tx_pop)      tx_count_nxt = tx_count + CW'(1);
    else if (~tx_push & tx_pop) tx_count_nxt = tx_count - CW'(1);
    if (tx_flush)               tx_count_nxt = '0;
  end

  always_comb begin
    rx_count_nxt = rx_count;
    if (rx_push_eff & ~rx_pop)      rx_count_nxt = rx_count + CW'(1);
    else if (~rx_push_eff & rx_pop) rx_count_nxt = rx_count - CW'(1);
    if (rx_flush)                   rx_count_nxt = '0;
  end

  // Read data reflects state before the accept edge.
  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (sel)
        2'd1:    rd_data = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr];
        2'd2:    rd_data = {12'd0, rx_unf, tx_ovf, rx_empty, tx_full,
                            8'(rx_count), 8'(tx_count)};
        2'd3:    rd_data = {29'd0, irq_en, 2'b00};
        default: rd_data = '0;
      endcase
    end
  end

  // Stage p1: bus response, FIFO control and flags
  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      irq_en    <= 1'b0;
      ack_p1    <= 1'b0;
      err_p1    <= 1'b0;
      dat_p1    <= '0;
      irq_p1    <= 1'b0;
    end else begin
      tx_wr_ptr <= tx_flush ? '0 : tx_wr_ptr + AW'(tx_push);
      tx_rd_ptr <= tx_flush ? '0 : tx_rd_ptr + AW'(tx_pop);
      tx_count  <= tx_count_nxt;
      rx_wr_ptr <= rx_flush ? '0 : rx_wr_ptr + AW'(rx_push_eff);
      rx_rd_ptr <= rx_flush ? '0 : rx_rd_ptr + AW'(rx_pop);
      rx_count  <= rx_count_nxt;
      tx_ovf    <= (tx_ovf & ~(status_wr & bus.WB_DAT_I[18])) | tx_reject;
      rx_unf    <= (rx_unf & ~(status_wr & bus.WB_DAT_I[19])) | rx_reject;
      irq_en    <= irq_en_nxt;
      ack_p1    <= accept & ~(tx_reject | rx_reject);
      err_p1    <= tx_reject | rx_reject;
      dat_p1    <= rd_data;
      // Built from next-state values so IRQ_O tracks the FIFO without extra lag.
      irq_p1    <= irq_en_nxt & (rx_count_nxt != '0);
    end
  end

  // FIFO storage carries no reset; validity is governed by the counts.
  always_ff @(posedge WB_CLK_I) begin
    if (tx_push)     tx_mem[tx_wr_ptr] <= bus.WB_DAT_I;
    if (rx_push_eff) rx_mem[rx_wr_ptr] <= bus.RX_DATA_I;
  end

  assign bus.WB_ACK_O   = ack_p1;
  assign bus.WB_ERR_O   = err_p1;
  assign bus.WB_DAT_O   = dat_p1;
  assign bus.WB_RTY_O   = 1'b0;
  assign bus.WB_STALL_O = 1'b0;
  assign bus.TX_VALID_O = ~tx_empty;
  assign bus.TX_DATA_O  = tx_mem[tx_rd_ptr];
  assign bus.RX_READY_O = ~rx_full;
  assign IRQ_O          = irq_p1;
endmodule
